se_pair_scheduler: RTL

//  Sequences one operation at a time into two SE instances for a self-composition timing check.
//  - Both instances get the same public inst/op1/op2.
//  - Each instance gets its own secret cond.
//  - Measures each instance's completion latency and reports results, latencies, a timing-leak flag and a mismatch flag.
//  - Sits between the tester stimulus source and the pair of SE copies; replaces direct fan-out wiring.

---
 rtl/se_pair_scheduler_if.sv | 81 ++++++++
 rtl/se_pair_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/se_pair_scheduler_if.sv
// ---------------------------------------------------------------------------
// se_pair_scheduler_if
// Bundles every handshake/data signal around the SE pair scheduler:
//   cmd_*          tester command channel (valid/ready)
//   se_*           shared inst/op1/op2 plus per-instance cond, request and
//                  result channels for SE instances A and B
//   rpt_*          report channel (results, latencies, leak/mismatch/timeout)
//   leak_seen      sticky leak indication (tied 0 unless
//                  SE_SCHED_LEAK_STICKY_EN is defined in the scheduler build)
// Modports:
//   slave  - scheduler view
//   master - environment view (tester source, both SE copies, report sink)
// ---------------------------------------------------------------------------
interface se_pair_scheduler_if #(
    parameter int DATA_W = 128,
    parameter int INST_W = 8,
    parameter int LAT_W  = 16
);
    logic [INST_W-1:0] cmd_inst;
    logic [DATA_W-1:0] cmd_op1;
    logic [DATA_W-1:0] cmd_op2;
    logic [DATA_W-1:0] cmd_cond_a;
    logic [DATA_W-1:0] cmd_cond_b;
    logic              cmd_valid;
    logic              cmd_ready;

    logic [INST_W-1:0] se_inst;
    logic [DATA_W-1:0] se_op1;
    logic [DATA_W-1:0] se_op2;
    logic [DATA_W-1:0] se_cond_a;
    logic [DATA_W-1:0] se_cond_b;
    logic              se_in_valid_a;
    logic              se_in_valid_b;
    logic              se_in_ready_a;
    logic              se_in_ready_b;
    logic [DATA_W-1:0] se_result_a;
    logic [DATA_W-1:0] se_result_b;
    logic              se_out_valid_a;
    logic              se_out_valid_b;
    logic              se_out_ready_a;
    logic              se_out_ready_b;

    logic [DATA_W-1:0] rpt_result_a;
    logic [DATA_W-1:0] rpt_result_b;
    logic [LAT_W-1:0]  rpt_lat_a;
    logic [LAT_W-1:0]  rpt_lat_b;
    logic              rpt_leak;
    logic              rpt_mismatch;
    logic              rpt_timeout;
    logic              rpt_valid;
    logic              rpt_ready;
    logic              leak_seen;

    modport slave (
        input  cmd_inst, cmd_op1, cmd_op2, cmd_cond_a, cmd_cond_b, cmd_valid,
        output cmd_ready,
        output se_inst, se_op1, se_op2, se_cond_a, se_cond_b,
        output se_in_valid_a, se_in_valid_b,
        input  se_in_ready_a, se_in_ready_b,
        input  se_result_a, se_result_b, se_out_valid_a, se_out_valid_b,
        output se_out_ready_a, se_out_ready_b,
        output rpt_result_a, rpt_result_b, rpt_lat_a, rpt_lat_b,
        output rpt_leak, rpt_mismatch, rpt_timeout, rpt_valid,
        input  rpt_ready,
        output leak_seen
    );

    modport master (
        output cmd_inst, cmd_op1, cmd_op2, cmd_cond_a, cmd_cond_b, cmd_valid,
        input  cmd_ready,
        input  se_inst, se_op1, se_op2, se_cond_a, se_cond_b,
        input  se_in_valid_a, se_in_valid_b,
        output se_in_ready_a, se_in_ready_b,
        output se_result_a, se_result_b, se_out_valid_a, se_out_valid_b,
        input  se_out_ready_a, se_out_ready_b,
        input  rpt_result_a, rpt_result_b, rpt_lat_a, rpt_lat_b,
        input  rpt_leak, rpt_mismatch, rpt_timeout, rpt_valid,
        output rpt_ready,
        input  leak_seen
    );
endinterface

// File: rtl/se_pair_scheduler.sv
// ---------------------------------------------------------------------------
// se_pair_scheduler
// Issues one operation at a time to two SE instances (same public inst/op1/
// op2, private cond per instance), measures each instance's completion
// latency and reports results, latencies, leak/mismatch/timeout flags.
//
// Ports:
//   clock    - system clock
//   reset_n  - asynchronous active-low reset
//   bus      - se_pair_scheduler_if.slave (cmd, SE A/B, report channels)
//
// Build option:
//   SE_SCHED_LEAK_STICKY_EN - when defined, leak_seen is a sticky OR of
//                             rpt_leak|rpt_timeout over all reports, cleared
//                             only by reset_n; otherwise leak_seen is tied 0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | cmd_ready high, waiting for a command
// S_ISSUE  | presenting the request to whichever side has not accepted yet
// S_WAIT   | both accepted, collecting remaining results
// S_REPORT | rpt_valid high, holding the report until rpt_ready
// ---------------------------------------------------------------------------
module se_pair_scheduler #(
    parameter int DATA_W  = 128,
    parameter int INST_W  = 8,
    parameter int LAT_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                clock,
    input  logic                reset_n,
    se_pair_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [INST_W-1:0] r_inst;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [DATA_W-1:0] r_cond_a;
    logic [DATA_W-1:0] r_cond_b;

    logic              r_acc_a;
    logic              r_acc_b;
    logic              r_cap_a;
    logic              r_cap_b;
    logic [LAT_W-1:0]  r_cyc;

    logic [DATA_W-1:0] r_cap_res_a;
    logic [DATA_W-1:0] r_cap_res_b;
    logic [LAT_W-1:0]  r_cap_lat_a;
    logic [LAT_W-1:0]  r_cap_lat_b;

    logic [DATA_W-1:0] r_rpt_res_a;
    logic [DATA_W-1:0] r_rpt_res_b;
    logic [LAT_W-1:0]  r_rpt_lat_a;
    logic [LAT_W-1:0]  r_rpt_lat_b;
    logic              r_rpt_leak;
    logic              r_rpt_mismatch;
    logic              r_rpt_timeout;

    logic              w_active;
    logic              w_in_valid_a;
    logic              w_in_valid_b;
    logic              w_in_hs_a;
    logic              w_in_hs_b;
    logic              w_out_ready_a;
    logic              w_out_ready_b;
    logic              w_out_hs_a;
    logic              w_out_hs_b;
    logic              w_done;
    logic              w_tmo;
    logic              w_rpt_enter;
    logic [DATA_W-1:0] w_fin_res_a;
    logic [DATA_W-1:0] w_fin_res_b;
    logic [LAT_W-1:0]  w_fin_lat_a;
    logic [LAT_W-1:0]  w_fin_lat_b;

    assign w_active      = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_in_valid_a  = (r_state == S_ISSUE) && !r_acc_a;
    assign w_in_valid_b  = (r_state == S_ISSUE) && !r_acc_b;
    assign w_in_hs_a     = w_in_valid_a && bus.se_in_ready_a;
    assign w_in_hs_b     = w_in_valid_b && bus.se_in_ready_b;
    assign w_out_ready_a = w_active && r_acc_a && !r_cap_a;
    assign w_out_ready_b = w_active && r_acc_b && !r_cap_b;
    assign w_out_hs_a    = w_out_ready_a && bus.se_out_valid_a;
    assign w_out_hs_b    = w_out_ready_b && bus.se_out_valid_b;

    // Completion includes a capture happening in this very cycle, so a pair
    // of 1-cycle SEs turns around in IDLE/ISSUE/WAIT/REPORT = 4 cycles.
    assign w_done = (r_state == S_WAIT) && (r_cap_a || w_out_hs_a) && (r_cap_b || w_out_hs_b);
    assign w_tmo  = w_active && !w_done && (r_cyc == LAT_W'(TIMEOUT));
    assign w_rpt_enter = w_done || w_tmo;

    // Values loaded into the report on entry; an uncaptured side reports
    // result 0 with an all-ones latency.
    assign w_fin_res_a = w_out_hs_a ? bus.se_result_a : (r_cap_a ? r_cap_res_a : '0);
    assign w_fin_res_b = w_out_hs_b ? bus.se_result_b : (r_cap_b ? r_cap_res_b : '0);
    assign w_fin_lat_a = w_out_hs_a ? r_cyc : (r_cap_a ? r_cap_lat_a : '1);
    assign w_fin_lat_b = w_out_hs_b ? r_cyc : (r_cap_b ? r_cap_lat_b : '1);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_tmo) begin
                    w_next_state = S_REPORT;
                end else if ((r_acc_a || w_in_hs_a) && (r_acc_b || w_in_hs_b)) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_rpt_enter) begin
                    w_next_state = S_REPORT;
                end
            end
            S_REPORT: begin
                if (bus.rpt_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inst         <= '0;
            r_op1          <= '0;
            r_op2          <= '0;
            r_cond_a       <= '0;
            r_cond_b       <= '0;
            r_acc_a        <= 1'b0;
            r_acc_b        <= 1'b0;
            r_cap_a        <= 1'b0;
            r_cap_b        <= 1'b0;
            r_cyc          <= '0;
            r_cap_res_a    <= '0;
            r_cap_res_b    <= '0;
            r_cap_lat_a    <= '0;
            r_cap_lat_b    <= '0;
            r_rpt_res_a    <= '0;
            r_rpt_res_b    <= '0;
            r_rpt_lat_a    <= '0;
            r_rpt_lat_b    <= '0;
            r_rpt_leak     <= 1'b0;
            r_rpt_mismatch <= 1'b0;
            r_rpt_timeout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_inst   <= bus.cmd_inst;
                        r_op1    <= bus.cmd_op1;
                        r_op2    <= bus.cmd_op2;
                        r_cond_a <= bus.cmd_cond_a;
                        r_cond_b <= bus.cmd_cond_b;
                        r_acc_a  <= 1'b0;
                        r_acc_b  <= 1'b0;
                        r_cap_a  <= 1'b0;
                        r_cap_b  <= 1'b0;
                        r_cyc    <= '0;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (w_in_hs_a) r_acc_a <= 1'b1;
                    if (w_in_hs_b) r_acc_b <= 1'b1;
                    if (w_out_hs_a) begin
                        r_cap_a     <= 1'b1;
                        r_cap_res_a <= bus.se_result_a;
                        r_cap_lat_a <= r_cyc;
                    end
                    if (w_out_hs_b) begin
                        r_cap_b     <= 1'b1;
                        r_cap_res_b <= bus.se_result_b;
                        r_cap_lat_b <= r_cyc;
                    end
                    if (r_cyc != '1) begin
                        r_cyc <= r_cyc + LAT_W'(1);
                    end
                    if (w_rpt_enter) begin
                        r_rpt_res_a    <= w_fin_res_a;
                        r_rpt_res_b    <= w_fin_res_b;
                        r_rpt_lat_a    <= w_fin_lat_a;
                        r_rpt_lat_b    <= w_fin_lat_b;
                        r_rpt_leak     <= (w_fin_lat_a != w_fin_lat_b);
                        r_rpt_mismatch <= (w_fin_res_a != w_fin_res_b);
                        r_rpt_timeout  <= w_tmo;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SE_SCHED_LEAK_STICKY_EN
    logic r_leak_seen;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_leak_seen <= 1'b0;
        end else if (w_rpt_enter && ((w_fin_lat_a != w_fin_lat_b) || w_tmo)) begin
            r_leak_seen <= 1'b1;
        end
    end

    assign bus.leak_seen = r_leak_seen;
`else
    assign bus.leak_seen = 1'b0;
`endif

    // Gated by reset_n so cmd_ready reads 0 while reset is held.
    assign bus.cmd_ready      = (r_state == S_IDLE) && reset_n;
    assign bus.se_inst        = r_inst;
    assign bus.se_op1         = r_op1;
    assign bus.se_op2         = r_op2;
    assign bus.se_cond_a      = r_cond_a;
    assign bus.se_cond_b      = r_cond_b;
    assign bus.se_in_valid_a  = w_in_valid_a;
    assign bus.se_in_valid_b  = w_in_valid_b;
    assign bus.se_out_ready_a = w_out_ready_a;
    assign bus.se_out_ready_b = w_out_ready_b;
    assign bus.rpt_result_a   = r_rpt_res_a;
    assign bus.rpt_result_b   = r_rpt_res_b;
    assign bus.rpt_lat_a      = r_rpt_lat_a;
    assign bus.rpt_lat_b      = r_rpt_lat_b;
    assign bus.rpt_leak       = r_rpt_leak;
    assign bus.rpt_mismatch   = r_rpt_mismatch;
    assign bus.rpt_timeout    = r_rpt_timeout;
    assign bus.rpt_valid      = (r_state == S_REPORT);

endmodule
